// File: rtl/hp_digit_entry.sv
// hp_digit_entry: two-digit decimal entry (tens/ones stepped by key edges)
// converted to binary and offered to a consumer over a valid/ack handshake.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inc_ones, inc_tens, commit    level inputs, acted on at their rising edge
//   ack                           consumer accepts out_value while out_valid=1
//   ones_dgt, tens_dgt            current digits (registered)
//   live_value                    tens*10+ones clamped to MAX_VALUE (combinational)
//   out_value, out_valid          committed value and pending flag
//   err                           one-cycle pulse on an out-of-range commit
//   busy                          entry frozen while a value is pending
module hp_digit_entry #(
   parameter int unsigned VALUE_W   = 4,
   parameter int unsigned MAX_VALUE = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc_ones,
   input  logic               inc_tens,
   input  logic               commit,
   input  logic               ack,
   output logic [3:0]         ones_dgt,
   output logic [3:0]         tens_dgt,
   output logic [VALUE_W-1:0] live_value,
   output logic [VALUE_W-1:0] out_value,
   output logic               out_valid,
   output logic               err,
   output logic               busy
);

   localparam int unsigned DGT_W    = 4;
   localparam int unsigned SUM_W    = VALUE_W + 1;
   localparam int unsigned TENS_MAX = MAX_VALUE / 10;

   typedef enum logic {ST_EDIT = 1'b0, ST_HOLD = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [DGT_W-1:0]   ones_q, ones_d;
   logic [DGT_W-1:0]   tens_q, tens_d;
   logic [VALUE_W-1:0] out_value_q, out_value_d;
   logic               out_valid_q, out_valid_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               inc_ones_q, inc_tens_q, commit_q;

   logic               ones_ev, tens_ev, commit_ev;
   logic [SUM_W-1:0]   sum;
   logic               sum_ok;

   assign ones_ev   = inc_ones & ~inc_ones_q;
   assign tens_ev   = inc_tens & ~inc_tens_q;
   assign commit_ev = commit & ~commit_q;

   // One extra bit so e.g. 19 is not aliased into range before the check.
   assign sum    = SUM_W'(tens_q) * SUM_W'(10) + SUM_W'(ones_q);
   assign sum_ok = (sum <= SUM_W'(MAX_VALUE));

   // State and datapath registers; history regs reset high to mask held keys.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EDIT;
         ones_q      <= '0;
         tens_q      <= '0;
         out_value_q <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         inc_ones_q  <= 1'b1;
         inc_tens_q  <= 1'b1;
         commit_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         ones_q      <= ones_d;
         tens_q      <= tens_d;
         out_value_q <= out_value_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         inc_ones_q  <= inc_ones;
         inc_tens_q  <= inc_tens;
         commit_q    <= commit;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (state_q == ST_EDIT) begin
         if (commit_ev && sum_ok) state_d = ST_HOLD;
      end else begin
         if (ack) state_d = ST_EDIT;
      end
   end

   // Output/datapath logic; commit takes priority over same-cycle increments.
   always_comb begin
      ones_d      = ones_q;
      tens_d      = tens_q;
      out_value_d = out_value_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      err_d       = 1'b0;
      if (state_q == ST_EDIT) begin
         if (commit_ev) begin
            if (sum_ok) begin
               out_value_d = sum[VALUE_W-1:0];
               out_valid_d = 1'b1;
               busy_d      = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end else begin
            if (ones_ev) ones_d = (ones_q == DGT_W'(9)) ? '0 : ones_q + DGT_W'(1);
            if (tens_ev) tens_d = (tens_q == DGT_W'(TENS_MAX)) ? '0 : tens_q + DGT_W'(1);
         end
      end else begin
         if (ack) begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            ones_d      = '0;
            tens_d      = '0;
         end
      end
   end

   assign live_value = (sum > SUM_W'(MAX_VALUE)) ? VALUE_W'(MAX_VALUE) : sum[VALUE_W-1:0];
   assign ones_dgt   = ones_q;
   assign tens_dgt   = tens_q;
   assign out_value  = out_value_q;
   assign out_valid  = out_valid_q;
   assign err        = err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_hp_digit_entry.sv
// tb_hp_digit_entry: vector table, directed corner sequences and a random
// run checked against a behavioural digit-entry model.
module tb_hp_digit_entry;

   localparam int MAXV = 15;

   logic       clk, rst, inc_ones, inc_tens, commit, ack;
   logic [3:0] ones_dgt, tens_dgt, live_value, out_value;
   logic       out_valid, err, busy;

   int checks = 0;
   int errors = 0;

   // Behavioural model state.
   int m_ones, m_tens, m_val, m_valid, m_err, p_io, p_it, p_cm;

   hp_digit_entry #(.VALUE_W(4), .MAX_VALUE(MAXV)) dut (
      .clk(clk), .rst(rst), .inc_ones(inc_ones), .inc_tens(inc_tens),
      .commit(commit), .ack(ack), .ones_dgt(ones_dgt), .tens_dgt(tens_dgt),
      .live_value(live_value), .out_value(out_value), .out_valid(out_valid),
      .err(err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int io, it, cm, ak;
      int ones, tens, live, val, valid, er, bsy;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(int io, int it, int cm, int ak, int o, int t,
                               int l, int v, int vl, int e, int b);
      vec_t r;
      r.io = io; r.it = it; r.cm = cm; r.ak = ak;
      r.ones = o; r.tens = t; r.live = l; r.val = v; r.valid = vl; r.er = e; r.bsy = b;
      return r;
   endfunction

   task automatic cmp(string tag, string f, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s.%s: got %0d expected %0d (t=%0t)", tag, f, act, exp, $time);
      end
   endtask

   task automatic expect_out(string tag, int o, int t, int l, int v, int vl, int e, int b);
      cmp(tag, "ones",  int'(ones_dgt),   o);
      cmp(tag, "tens",  int'(tens_dgt),   t);
      cmp(tag, "live",  int'(live_value), l);
      cmp(tag, "value", int'(out_value),  v);
      cmp(tag, "valid", int'(out_valid),  vl);
      cmp(tag, "err",   int'(err),        e);
      cmp(tag, "busy",  int'(busy),       b);
   endtask

   // Model of one clock edge, from the behavioural rules.
   task automatic m_update(int r, int io, int it, int cm, int ak);
      int s;
      if (r != 0) begin
         m_ones = 0; m_tens = 0; m_val = 0; m_valid = 0; m_err = 0;
         p_io = 1; p_it = 1; p_cm = 1;
         return;
      end
      m_err = 0;
      if (m_valid == 0) begin
         if (cm != 0 && p_cm == 0) begin
            s = m_tens * 10 + m_ones;
            if (s <= MAXV) begin m_val = s; m_valid = 1; end
            else m_err = 1;
         end else begin
            if (io != 0 && p_io == 0) m_ones = (m_ones + 1) % 10;
            if (it != 0 && p_it == 0) m_tens = (m_tens + 1) % (MAXV / 10 + 1);
         end
      end else if (ak != 0) begin
         m_valid = 0; m_ones = 0; m_tens = 0;
      end
      p_io = io; p_it = it; p_cm = cm;
   endtask

   // Apply inputs away from the edge, sample 1 time unit after it.
   task automatic cyc(int r, int io, int it, int cm, int ak);
      @(negedge clk);
      rst = 1'(r); inc_ones = 1'(io); inc_tens = 1'(it); commit = 1'(cm); ack = 1'(ak);
      @(posedge clk);
      #1;
      m_update(r, io, it, cm, ak);
   endtask

   task automatic pulse_ones(int n);
      repeat (n) begin cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0); end
   endtask

   task automatic pulse_tens(int n);
      repeat (n) begin cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0); end
   endtask

   initial begin
      int r, io, it, cm, ak;
      int ml;
      rst = 1'b1; inc_ones = 1'b0; inc_tens = 1'b0; commit = 1'b0; ack = 1'b0;

      // io it cm ak | ones tens live val valid err busy
      vecs[0]  = mk(0,0,0,0, 0,0, 0, 0,0,0,0);
      vecs[1]  = mk(1,0,0,0, 1,0, 1, 0,0,0,0);
      vecs[2]  = mk(0,0,0,0, 1,0, 1, 0,0,0,0);
      vecs[3]  = mk(1,0,0,0, 2,0, 2, 0,0,0,0);
      vecs[4]  = mk(0,0,0,0, 2,0, 2, 0,0,0,0);
      vecs[5]  = mk(1,0,0,0, 3,0, 3, 0,0,0,0);
      vecs[6]  = mk(0,0,0,0, 3,0, 3, 0,0,0,0);
      vecs[7]  = mk(0,1,0,0, 3,1,13, 0,0,0,0);
      vecs[8]  = mk(0,0,0,0, 3,1,13, 0,0,0,0);
      vecs[9]  = mk(0,0,1,0, 3,1,13,13,1,0,1);
      vecs[10] = mk(0,0,0,0, 3,1,13,13,1,0,1);
      vecs[11] = mk(0,0,0,1, 0,0, 0,13,0,0,0);
      vecs[12] = mk(0,0,0,0, 0,0, 0,13,0,0,0);

      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      expect_out("reset", 0, 0, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         cyc(0, vecs[i].io, vecs[i].it, vecs[i].cm, vecs[i].ak);
         expect_out($sformatf("vec%0d", i), vecs[i].ones, vecs[i].tens, vecs[i].live,
                    vecs[i].val, vecs[i].valid, vecs[i].er, vecs[i].bsy);
      end

      // Ones wraps with no carry; tens wraps at 1.
      pulse_ones(10);
      expect_out("ones_wrap", 0, 0, 0, 13, 0, 0, 0);
      pulse_tens(1);
      expect_out("tens_one", 0, 1, 10, 13, 0, 0, 0);
      pulse_tens(1);
      expect_out("tens_wrap", 0, 0, 0, 13, 0, 0, 0);

      // Out-of-range commits are rejected with a single-cycle err.
      pulse_tens(1);
      pulse_ones(7);
      expect_out("d17", 7, 1, 15, 13, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      expect_out("rej17", 7, 1, 15, 13, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      expect_out("rej17_after", 7, 1, 15, 13, 0, 0, 0);
      pulse_ones(9);
      cyc(0, 0, 0, 1, 0);
      expect_out("rej16", 6, 1, 15, 13, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      expect_out("rej16_after", 6, 1, 15, 13, 0, 0, 0);
      pulse_ones(8);
      cyc(0, 0, 0, 1, 0);
      expect_out("commit14", 4, 1, 14, 14, 1, 0, 1);
      cyc(0, 0, 0, 0, 0);

      // HOLD ignores increments and commits; reset drops the pending value.
      cyc(0, 1, 0, 1, 0);
      expect_out("hold_ev", 4, 1, 14, 14, 1, 0, 1);
      for (int k = 0; k < 5; k++) begin
         cyc(0, 0, 0, 0, 0);
         expect_out($sformatf("hold%0d", k), 4, 1, 14, 14, 1, 0, 1);
      end
      cyc(1, 0, 0, 0, 0);
      expect_out("hold_rst", 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // Commit beats a simultaneous increment.
      pulse_ones(5);
      cyc(0, 1, 0, 1, 0);
      expect_out("commit_pri", 5, 0, 5, 5, 1, 0, 1);
      cyc(0, 0, 0, 0, 1);
      expect_out("ack", 0, 0, 0, 5, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      expect_out("ack_edit", 0, 0, 0, 5, 0, 0, 0);

      // A key held through reset release generates no event.
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, 0, 0, 0);
         expect_out($sformatf("held%0d", k), 0, 0, 0, 0, 0, 0, 0);
      end
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      expect_out("held_release", 1, 0, 1, 0, 0, 0, 0);

      // Random run against the model.
      for (int n = 0; n < 3000; n++) begin
         r  = ($urandom_range(0, 99) == 0) ? 1 : 0;
         io = int'($urandom_range(0, 1));
         it = int'($urandom_range(0, 1));
         cm = ($urandom_range(0, 3) == 0) ? 1 : 0;
         ak = ($urandom_range(0, 3) == 0) ? 1 : 0;
         cyc(r, io, it, cm, ak);
         ml = m_tens * 10 + m_ones;
         if (ml > MAXV) ml = MAXV;
         expect_out($sformatf("rnd%0d", n), m_ones, m_tens, ml, m_val, m_valid, m_err, m_valid);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
